shot_link_ctl: RTL and testbench
================================

// Module: shot_link_ctl
// PURPOSE
//  Link-layer controller between logic_ctl and the UART tx/rx pair that joins the two boards.
//  - Frames our shot address from logic_ctl (check_out/addres_sent) into a 2-byte SHOT frame.
//  - Waits for the opponent's RESULT frame and returns the result as msg_in.
//  - Parses the opponent's SHOT frames, queries our own board, replies with a RESULT frame and reports the outcome as msg_send.
// PARAMETERS
//  HDR_SHOT     8'hA5        header byte of a SHOT frame (payload = cell address {row[7:4],col[3:0]})
//  HDR_RES      8'h5A        header byte of a RESULT frame (payload = {6'b0, code[1:0]})
//  LOOKUP_LAT   2            cycles from board_query to a valid board_hit
//  TIMEOUT_CYC  100_000_000  maximum clk cycles spent in WAIT_RES (1 s at 100 MHz)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  shot_req     in   1  level; high = logic_ctl has a shot ready (addres_sent)
//  shot_addr    in   8  shot cell address (check_out)
//  msg_clr      in   1  one-cycle pulse; clears msg_in and msg_send
//  rx_data      in   8  received byte
//  rx_valid     in   1  one-cycle strobe; rx_data is valid
//  tx_busy      in   1  UART transmitter busy
//  tx_data      out  8  byte to transmit
//  tx_start     out  1  one-cycle strobe; start transmitting tx_data
//  board_addr   out  8  own-board cell to check (addres4check path)
//  board_query  out  1  one-cycle strobe; start an own-board lookup
//  board_hit    in   1  lookup result, valid LOOKUP_LAT cycles after board_query
//  opp_addr     out  8  last opponent shot address (check_in)
//  msg_in       out  2  result of our shot: 00 none, 01 miss, 10 hit, 11 link error
//  msg_send     out  2  result sent for the opponent's shot: 00 none, 01 miss, 10 hit
//  busy         out  1  high whenever the main FSM is not in IDLE
// BEHAVIOUR
//  Reset:
//  - All outputs are 0; both FSMs return to their idle states; the pending-shot register and timeout counter clear.
//  - A reset mid-frame abandons the frame; nothing partial is transmitted afterwards.
//  RX parser FSM (R_HDR, R_PAY):
//  - R_HDR: a byte equal to HDR_SHOT or HDR_RES latches the frame type and moves to R_PAY. Any other byte is discarded.
//  - R_PAY: the next rx_valid byte completes the frame. Go back to R_HDR and raise a one-cycle internal event: shot_evt(addr) or res_evt(code).
//  Main FSM (IDLE, TX_HDR, TX_PAY, WAIT_RES, LOOKUP, RPL_HDR, RPL_PAY):
//  - IDLE: a pending opponent shot has priority over shot_req.
//    - Pending shot -> LOOKUP.
//    - Otherwise shot_req = 1 -> latch shot_addr, clear msg_in, go to TX_HDR.
//  - TX_HDR, TX_PAY, RPL_HDR, RPL_PAY: when tx_busy = 0, drive tx_data and pulse tx_start for 1 cycle, then advance.
//    - The next byte waits until tx_busy rises and falls again; no byte is ever dropped.
//  - After TX_PAY -> WAIT_RES with the timeout counter at 0.
//  - WAIT_RES:
//    - res_evt -> msg_in = code (01 or 10), go to IDLE.
//    - Counter reaches TIMEOUT_CYC-1 -> msg_in = 11, go to IDLE.
//    - A res_evt arriving in any other state is ignored.
//  - LOOKUP: on entry, set board_addr = opp_addr and pulse board_query. After exactly LOOKUP_LAT cycles, latch board_hit, then go to RPL_HDR.
//  - RPL_PAY payload is {6'b0, board_hit ? 2'b10 : 2'b01}. On leaving RPL_PAY, msg_send takes that same code and the FSM goes to IDLE.
//  Opponent shots (shot_evt):
//  - Every shot_evt sets opp_addr and the pending flag, in any main-FSM state.
//  - Pending depth is 1; a second shot_evt before service overwrites the address.
//  - The pending flag clears when LOOKUP is entered.
//  Simultaneous events:
//  - shot_evt and res_evt in the same cycle cannot occur, because the parser emits at most 1 event per cycle.
//  - shot_req while busy = 1 is held by the requester. It is accepted on the first IDLE cycle with no pending shot.
//  - A shot_req that is still high after completion starts a new shot. logic_ctl must drop it before that.
//  Result outputs:
//  - msg_in and msg_send are sticky until msg_clr. logic_ctl samples them only once per video frame, so they must hold.
//  - msg_clr in the same cycle as a new update: the update wins.
// STRUCTURE
//  - vga_pkg (or a new link_pkg) holds:
//    - the HDR_* defaults;
//    - the MSG_NONE, MSG_MISS, MSG_HIT, MSG_ERR 2-bit constants;
//    - typedef enum bit [2:0] LINK_STATE_T.
//  - Sub-module: link_rx_parser (the R_HDR/R_PAY FSM with its event outputs); the main FSM stays in this file.
// TESTING
//  1. shot_req = 1, shot_addr = 8'h34, UART model replies A5 34 -> 5A 02:
//     - tx bytes are A5 then 34;
//     - msg_in = 2'b10 after the reply; busy returns to 0.
//  2. rx A5 57, board model returns board_hit = 0 after 2 cycles:
//     - board_addr = 8'h57 with a 1-cycle board_query;
//     - tx bytes are 5A then 01;
//     - msg_send = 2'b01; opp_addr = 8'h57.
//  3. shot_req, then no reply (run with TIMEOUT_CYC = 50):
//     - msg_in = 2'b11 exactly 50 cycles after the last tx_start;
//     - FSM is back in IDLE.
//  4. While in WAIT_RES for shot 8'h12, rx A5 99, then 5A 01:
//     - msg_in = 01;
//     - then a reply to 8'h99 is sent with no shot_req needed.
//  5. rx garbage bytes FF 00 followed by A5 10:
//     - the garbage is ignored;
//     - exactly one lookup of 8'h10 occurs.
//  6. rst asserted between TX_HDR and TX_PAY:
//     - tx_start stays 0 for the rest of the frame;
//     - all outputs read 0 on the cycle after rst.

Source files
------------

// File: rtl/shot_link_ctl_pkg.sv
// Shared constants, state types and helpers for the board-to-board shot link.
package shot_link_ctl_pkg;

  localparam logic [7:0] HDR_SHOT_DEF    = 8'hA5;
  localparam logic [7:0] HDR_RES_DEF     = 8'h5A;
  localparam int         LOOKUP_LAT_DEF  = 2;
  localparam int         TIMEOUT_CYC_DEF = 100_000_000;

  localparam logic [1:0] MSG_NONE = 2'b00;
  localparam logic [1:0] MSG_MISS = 2'b01;
  localparam logic [1:0] MSG_HIT  = 2'b10;
  localparam logic [1:0] MSG_ERR  = 2'b11;

  typedef enum bit [2:0] {
    IDLE,
    TX_HDR,
    TX_PAY,
    WAIT_RES,
    LOOKUP,
    RPL_HDR,
    RPL_PAY
  } LINK_STATE_T;

  typedef enum logic {
    R_HDR,
    R_PAY
  } rx_state_t;

  typedef enum logic {
    FT_SHOT,
    FT_RES
  } frame_t;

  function automatic logic [1:0] hit_code(input logic hit);
    return hit ? MSG_HIT : MSG_MISS;
  endfunction

endpackage

// File: rtl/shot_link_ctl_if.sv
// UART byte pair and own-board lookup port seen by the link controller.
interface shot_link_ctl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] board_addr;
  logic       board_query;
  logic       board_hit;

  modport master (
    input  rx_data, rx_valid, tx_busy, board_hit,
    output tx_data, tx_start, board_addr, board_query
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, board_hit,
    input  tx_data, tx_start, board_addr, board_query
  );
endinterface

// File: rtl/shot_link_ctl_rx_parser.sv
// Two-byte frame parser: header selects SHOT or RESULT, payload raises a one-cycle event.
module link_rx_parser
  import shot_link_ctl_pkg::*;
#(
  parameter logic [7:0] HDR_SHOT = HDR_SHOT_DEF,
  parameter logic [7:0] HDR_RES  = HDR_RES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       shot_evt,
  output logic       res_evt,
  output logic [7:0] evt_data
);

  rx_state_t  state, state_n;
  frame_t     ftype, ftype_n;
  logic       shot_evt_n, res_evt_n;
  logic [7:0] evt_data_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= R_HDR;
      ftype    <= FT_SHOT;
      shot_evt <= 1'b0;
      res_evt  <= 1'b0;
      evt_data <= 8'h00;
    end else begin
      state    <= state_n;
      ftype    <= ftype_n;
      shot_evt <= shot_evt_n;
      res_evt  <= res_evt_n;
      evt_data <= evt_data_n;
    end
  end

  always_comb begin
    state_n    = state;
    ftype_n    = ftype;
    shot_evt_n = 1'b0;
    res_evt_n  = 1'b0;
    evt_data_n = evt_data;
    case (state)
      R_HDR: begin
        // Bytes that are not a known header are dropped so the parser resyncs.
        if (rx_valid && rx_data == HDR_SHOT) begin
          ftype_n = FT_SHOT;
          state_n = R_PAY;
        end else if (rx_valid && rx_data == HDR_RES) begin
          ftype_n = FT_RES;
          state_n = R_PAY;
        end
      end
      R_PAY: begin
        if (rx_valid) begin
          state_n    = R_HDR;
          evt_data_n = rx_data;
          if (ftype == FT_SHOT) shot_evt_n = 1'b1;
          else                  res_evt_n  = 1'b1;
        end
      end
      default: state_n = R_HDR;
    endcase
  end

endmodule

// File: rtl/shot_link_ctl.sv
// Link-layer controller: frames our shots, awaits results, answers opponent shots from our board.
module shot_link_ctl
  import shot_link_ctl_pkg::*;
#(
  parameter logic [7:0] HDR_SHOT    = HDR_SHOT_DEF,
  parameter logic [7:0] HDR_RES     = HDR_RES_DEF,
  parameter int         LOOKUP_LAT  = LOOKUP_LAT_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shot_req,
  input  logic [7:0]         shot_addr,
  input  logic               msg_clr,
  shot_link_ctl_if.master    link,
  output logic [7:0]         opp_addr,
  output logic [1:0]         msg_in,
  output logic [1:0]         msg_send,
  output logic               busy
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LW = $clog2(LOOKUP_LAT + 1) + 1;

  LINK_STATE_T state, state_n;

  logic          shot_evt, res_evt;
  logic [7:0]    evt_data;
  logic [TW-1:0] tmo_cnt;
  logic [LW-1:0] lk_cnt;
  logic          pend, tx_wait_rise, hit_q;
  logic [7:0]    shot_lat;
  logic [7:0]    tx_data_q, board_addr_q;
  logic          tx_start_q, board_query_q;

  logic          can_send, send, accept, enter_lookup;
  logic          res_done, tmo_done, latch_hit, rpl_done;
  logic [7:0]    send_byte;

  link_rx_parser #(.HDR_SHOT(HDR_SHOT), .HDR_RES(HDR_RES)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (link.rx_data),
    .rx_valid (link.rx_valid),
    .shot_evt (shot_evt),
    .res_evt  (res_evt),
    .evt_data (evt_data)
  );

  // A new byte may start only after the previous one was seen busy and then idle.
  assign can_send = !link.tx_busy && !tx_wait_rise;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    send         = 1'b0;
    send_byte    = 8'h00;
    accept       = 1'b0;
    enter_lookup = 1'b0;
    res_done     = 1'b0;
    tmo_done     = 1'b0;
    latch_hit    = 1'b0;
    rpl_done     = 1'b0;
    case (state)
      IDLE: begin
        if (pend) begin
          state_n      = LOOKUP;
          enter_lookup = 1'b1;
        end else if (shot_req) begin
          state_n = TX_HDR;
          accept  = 1'b1;
        end
      end
      TX_HDR: if (can_send) begin
        send      = 1'b1;
        send_byte = HDR_SHOT;
        state_n   = TX_PAY;
      end
      TX_PAY: if (can_send) begin
        send      = 1'b1;
        send_byte = shot_lat;
        state_n   = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_evt) begin
          res_done = 1'b1;
          state_n  = IDLE;
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          tmo_done = 1'b1;
          state_n  = IDLE;
        end
      end
      LOOKUP: if (lk_cnt == LW'(LOOKUP_LAT)) begin
        latch_hit = 1'b1;
        state_n   = RPL_HDR;
      end
      RPL_HDR: if (can_send) begin
        send      = 1'b1;
        send_byte = HDR_RES;
        state_n   = RPL_PAY;
      end
      RPL_PAY: if (can_send) begin
        send      = 1'b1;
        send_byte = {6'b0, hit_code(hit_q)};
        rpl_done  = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      tx_wait_rise  <= 1'b0;
      board_addr_q  <= 8'h00;
      board_query_q <= 1'b0;
      pend          <= 1'b0;
      opp_addr      <= 8'h00;
      shot_lat      <= 8'h00;
      tmo_cnt       <= '0;
      lk_cnt        <= '0;
      hit_q         <= 1'b0;
      msg_in        <= MSG_NONE;
      msg_send      <= MSG_NONE;
    end else begin
      tx_start_q <= send;
      if (send) tx_data_q <= send_byte;
      if (send)              tx_wait_rise <= 1'b1;
      else if (link.tx_busy) tx_wait_rise <= 1'b0;

      board_query_q <= enter_lookup;
      if (enter_lookup) board_addr_q <= opp_addr;

      // A fresh opponent shot wins over the clear on LOOKUP entry.
      if (shot_evt)          pend <= 1'b1;
      else if (enter_lookup) pend <= 1'b0;
      if (shot_evt) opp_addr <= evt_data;

      if (accept) shot_lat <= shot_addr;
      tmo_cnt <= (state == WAIT_RES) ? tmo_cnt + 1'b1 : '0;
      lk_cnt  <= (state == LOOKUP)   ? lk_cnt + 1'b1  : '0;
      if (latch_hit) hit_q <= link.board_hit;

      if (res_done)               msg_in <= evt_data[1:0];
      else if (tmo_done)          msg_in <= MSG_ERR;
      else if (accept || msg_clr) msg_in <= MSG_NONE;

      if (rpl_done)     msg_send <= hit_code(hit_q);
      else if (msg_clr) msg_send <= MSG_NONE;
    end
  end

  assign link.tx_data     = tx_data_q;
  assign link.tx_start    = tx_start_q;
  assign link.board_addr  = board_addr_q;
  assign link.board_query = board_query_q;
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_shot_link_ctl.sv
// Directed bench for shot_link_ctl with a UART transmitter model and a 2-cycle board model.
module tb_shot_link_ctl;
  import shot_link_ctl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       shot_req = 1'b0;
  logic [7:0] shot_addr = 8'h00;
  logic       msg_clr = 1'b0;
  logic [7:0] opp_addr;
  logic [1:0] msg_in, msg_send;
  logic       busy;

  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tb_busy = 1'b0;
  logic       tb_hit = 1'b0;

  shot_link_ctl_if lif();
  assign lif.rx_data   = rx_data;
  assign lif.rx_valid  = rx_valid;
  assign lif.tx_busy   = tb_busy;
  assign lif.board_hit = tb_hit;

  shot_link_ctl #(.TIMEOUT_CYC(50)) dut (
    .clk       (clk),
    .rst       (rst),
    .shot_req  (shot_req),
    .shot_addr (shot_addr),
    .msg_clr   (msg_clr),
    .link      (lif),
    .opp_addr  (opp_addr),
    .msg_in    (msg_in),
    .msg_send  (msg_send),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // UART and board models
  logic [7:0] tx_q[$];
  int   cyc = 0, start_cyc = 0, busy_cnt = 0, lookup_cnt = 0;
  logic [7:0] q_addr = 8'h00;
  logic hit_val = 1'b0, s0 = 1'b0, s1 = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (lif.tx_start) begin
      tx_q.push_back(lif.tx_data);
      start_cyc = cyc;
      busy_cnt  = 4;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tb_busy = (busy_cnt != 0);
    tb_hit  = s1 & hit_val;
    s1      = s0;
    s0      = lif.board_query;
    if (lif.board_query) begin
      lookup_cnt++;
      q_addr = lif.board_addr;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input string name);
    int k = 0;
    while (tx_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, (tx_q.size() >= n), 1);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, busy, 0);
  endtask

  task automatic start_shot(input logic [7:0] a);
    tx_q.delete();
    shot_addr = a;
    shot_req  = 1'b1;
    @(negedge clk);
    shot_req  = 1'b0;
    check("busy after accept", busy, 1);
  endtask

  function automatic logic [31:0] all_outs();
    return {1'b0, lif.tx_data, lif.tx_start, lif.board_addr, lif.board_query,
            opp_addr, msg_in, msg_send, busy};
  endfunction

  typedef struct {
    bit         is_opp;
    logic [7:0] addr;
    logic [7:0] code;
    logic       hit;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    logic [1:0] exp_msg;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b0, 8'h34, 8'h02, 1'b0, 8'hA5, 8'h34, 2'b10};
    vecs[1] = '{1'b1, 8'h57, 8'h00, 1'b0, 8'h5A, 8'h01, 2'b01};
    vecs[2] = '{1'b0, 8'hC7, 8'h01, 1'b0, 8'hA5, 8'hC7, 2'b01};
    vecs[3] = '{1'b1, 8'h3B, 8'h00, 1'b1, 8'h5A, 8'h02, 2'b10};

    repeat (3) @(negedge clk);
    check("reset outputs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      if (!vecs[i].is_opp) begin
        start_shot(vecs[i].addr);
        wait_tx(2, "shot tx count");
        check("shot hdr", tx_q[0], vecs[i].exp_b0);
        check("shot pay", tx_q[1], vecs[i].exp_b1);
        send_rx(8'h5A);
        send_rx(vecs[i].code);
        wait_idle("shot idle");
        check("msg_in", msg_in, vecs[i].exp_msg);
      end else begin
        tx_q.delete();
        lookup_cnt = 0;
        hit_val    = vecs[i].hit;
        send_rx(8'hA5);
        send_rx(vecs[i].addr);
        wait_tx(2, "reply tx count");
        check("lookup addr", q_addr, vecs[i].addr);
        check("reply hdr", tx_q[0], vecs[i].exp_b0);
        check("reply pay", tx_q[1], vecs[i].exp_b1);
        wait_idle("reply idle");
        check("msg_send", msg_send, vecs[i].exp_msg);
        check("opp_addr", opp_addr, vecs[i].addr);
        check("one query pulse", lookup_cnt, 1);
      end
    end

    // Opponent shot arrives while we wait for our own result
    start_shot(8'h12);
    wait_tx(2, "t4 tx count");
    lookup_cnt = 0;
    hit_val    = 1'b1;
    send_rx(8'hA5);
    send_rx(8'h99);
    send_rx(8'h5A);
    send_rx(8'h01);
    check("t4 msg_in", msg_in, 2'b01);
    wait_tx(4, "t4 reply count");
    check("t4 reply hdr", tx_q[2], 8'h5A);
    check("t4 reply pay", tx_q[3], 8'h02);
    check("t4 lookup addr", q_addr, 8'h99);
    wait_idle("t4 idle");
    check("t4 msg_send", msg_send, 2'b10);

    // Garbage before a valid shot frame
    tx_q.delete();
    lookup_cnt = 0;
    hit_val    = 1'b0;
    send_rx(8'hFF);
    send_rx(8'h00);
    check("garbage ignored", busy, 0);
    send_rx(8'hA5);
    send_rx(8'h10);
    wait_tx(2, "t5 tx count");
    wait_idle("t5 idle");
    check("t5 lookups", lookup_cnt, 1);
    check("t5 lookup addr", q_addr, 8'h10);
    check("t5 reply pay", tx_q[1], 8'h01);

    // Results hold until cleared
    repeat (20) @(negedge clk);
    check("msg_in sticky", msg_in, 2'b01);
    check("msg_send sticky", msg_send, 2'b01);
    msg_clr = 1'b1;
    @(negedge clk);
    msg_clr = 1'b0;
    check("msg cleared", {msg_in, msg_send}, 4'b0000);

    // No reply: link error after the timeout
    start_shot(8'h21);
    wait_tx(2, "t3 tx count");
    begin
      int k = 0;
      while (msg_in != MSG_ERR && k < 300) begin
        @(negedge clk);
        k++;
      end
    end
    check("timeout msg_in", msg_in, 2'b11);
    check("timeout latency", cyc - start_cyc, 50);
    check("timeout idle", busy, 0);

    // Reset between header and payload
    start_shot(8'h44);
    wait_tx(1, "t6 hdr sent");
    rst = 1'b1;
    @(negedge clk);
    check("t6 outputs after rst", all_outs(), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t6 no further tx", tx_q.size(), 1);
    check("t6 idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
